stim_rr_scheduler: RTL and testbench

//  Round-robin scheduler that shares one driver channel among NREQ stimulus generators.
//  It is the RTL counterpart of the generator->driver "next"/"done" event handshake.
//  - Grants one requester at a time and forwards its item to the driver.
//  - Pulses a per-requester req_next when that item is taken.
//  - Pulses done once total_cnt items have been accepted by the driver.

---
 rtl/ipc_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/stim_rr_scheduler.sv | 148 ++++++++++++++
 tb/tb_stim_rr_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipc_pkg.sv
// Shared types and default sizes for the stimulus round-robin scheduler.
package ipc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;
  localparam int CW_DEF   = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int SW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic            gnt_valid,
  output logic [SW-1:0]   gnt_idx
);

  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/stim_rr_scheduler.sv
// Shares one driver channel among NREQ generators: round-robin grant, per-item req_next,
// done after total_cnt accepted items. Current FSM state is visible on state_dbg.
module stim_rr_scheduler
  import ipc_pkg::*;
#(
  parameter int  NREQ = NREQ_DEF,
  parameter int  DW   = DW_DEF,
  parameter int  CW   = CW_DEF,
  localparam int SW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CW-1:0]      total_cnt,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_next,
  output logic               drv_valid,
  output logic [DW-1:0]      drv_data,
  output logic [SW-1:0]      drv_src,
  input  logic               drv_ready,
  output logic               busy,
  output logic               done,
  output logic [CW-1:0]      sent_cnt,
  output sched_state_e       state_dbg
);

  // Handshake: an item moves to the driver on a cycle where drv_valid && drv_ready;
  // once raised, drv_valid/drv_data/drv_src stay put until that cycle (or abort/reset).
  sched_state_e  state, state_nx;
  logic [SW-1:0] rr_ptr, rr_ptr_nx;
  logic [CW-1:0] total_q, total_nx, sent_nx;
  logic          busy_nx, done_nx, drv_valid_nx;
  logic [DW-1:0] drv_data_nx;
  logic [SW-1:0] drv_src_nx;
  logic [NREQ-1:0] req_next_nx;
  logic          gnt_valid;
  logic [SW-1:0] gnt_idx;
  logic          xfer, last_item;

  rr_arbiter #(.NREQ(NREQ), .SW(SW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign xfer      = drv_valid && drv_ready;
  assign last_item = (sent_cnt + CW'(1)) == total_q;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start && total_cnt != '0) state_nx = ARB;
      ARB: begin
        if (abort)          state_nx = IDLE;
        else if (gnt_valid) state_nx = SEND;
      end
      SEND: begin
        if (abort)     state_nx = IDLE;
        else if (xfer) state_nx = last_item ? DONE : ARB;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values for every output register; abort always wins over a grant or transfer.
  always_comb begin
    rr_ptr_nx    = rr_ptr;
    total_nx     = total_q;
    sent_nx      = sent_cnt;
    busy_nx      = busy;
    done_nx      = 1'b0;
    drv_valid_nx = drv_valid;
    drv_data_nx  = drv_data;
    drv_src_nx   = drv_src;
    req_next_nx  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (total_cnt == '0) begin
            done_nx = 1'b1;
          end else begin
            busy_nx  = 1'b1;
            total_nx = total_cnt;
            sent_nx  = '0;
          end
        end
      end
      ARB: begin
        if (abort) begin
          busy_nx = 1'b0;
        end else if (gnt_valid) begin
          drv_valid_nx = 1'b1;
          drv_data_nx  = req_data[int'(gnt_idx)*DW +: DW];
          drv_src_nx   = gnt_idx;
          req_next_nx  = NREQ'(1) << gnt_idx;
          rr_ptr_nx    = (gnt_idx == SW'(NREQ - 1)) ? '0 : gnt_idx + SW'(1);
        end
      end
      SEND: begin
        if (abort) begin
          drv_valid_nx = 1'b0;
          busy_nx      = 1'b0;
        end else if (xfer) begin
          drv_valid_nx = 1'b0;
          sent_nx      = sent_cnt + CW'(1);
          done_nx      = last_item;
        end
      end
      DONE:    busy_nx = 1'b0;
      default: busy_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      total_q   <= '0;
      sent_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drv_valid <= 1'b0;
      drv_data  <= '0;
      drv_src   <= '0;
      req_next  <= '0;
    end else begin
      rr_ptr    <= rr_ptr_nx;
      total_q   <= total_nx;
      sent_cnt  <= sent_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      drv_valid <= drv_valid_nx;
      drv_data  <= drv_data_nx;
      drv_src   <= drv_src_nx;
      req_next  <= req_next_nx;
    end
  end

endmodule

// File: tb/tb_stim_rr_scheduler.sv
// Self-checking bench for stim_rr_scheduler: directed scenarios plus randomized runs
// compared against a transaction-level reference model.
module tb_stim_rr_scheduler;
  import ipc_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int CW   = 16;
  localparam int SW   = $clog2(NREQ);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [CW-1:0]      total_cnt = '0;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_next;
  logic               drv_valid;
  logic [DW-1:0]      drv_data;
  logic [SW-1:0]      drv_src;
  logic               drv_ready = 1'b0;
  logic               busy;
  logic               done;
  logic [CW-1:0]      sent_cnt;
  sched_state_e       state_dbg;

  stim_rr_scheduler #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .total_cnt (total_cnt),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_next  (req_next),
    .drv_valid (drv_valid),
    .drv_data  (drv_data),
    .drv_src   (drv_src),
    .drv_ready (drv_ready),
    .busy      (busy),
    .done      (done),
    .sent_cnt  (sent_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- generator side ----------------
  logic [NREQ-1:0] item_v = '0;
  logic [DW-1:0]   item_d [NREQ];
  logic [NREQ-1:0] gen_mask = '1;
  int refill_pct = 100, withdraw_pct = 0, ready_pct = 100;

  assign req_valid = item_v;
  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = item_d[i];
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int   src_log[$];
  int   m_ptr = 0, m_total = 0, m_sent = 0;
  bit   m_busy = 0, done_prev = 0, arb_prev = 0, prev_valid = 0;
  logic [DW-1:0] held_d = '0;
  logic [SW-1:0] held_s = '0;
  int   n_checks = 0, n_fail = 0;
  int   n_done = 0, n_next0 = 0, n_next = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at the falling edge: judges the rising edge that just happened.
  task automatic monitor();
    bit xfer, exp_done, grant_due, new_item;
    int winner, idx;
    logic [DW-1:0] exp_item;
    xfer      = prev_valid && drv_ready && !abort;
    exp_done  = 1'b0;
    grant_due = arb_prev && !abort && (item_v != '0);
    if (m_busy && abort) begin
      m_busy = 1'b0;
      if (prev_valid && exp_q.size() > 0) exp_q.delete(0);
    end else if (m_busy && done_prev) begin
      m_busy = 1'b0;
    end else if (m_busy && xfer) begin
      m_sent++;
      if (exp_q.size() == 0) check("xfer_item_known", 0, 1);
      else begin
        exp_item = exp_q.pop_front();
        check("xfer_data", 32'(held_d), 32'(exp_item));
      end
      if (m_sent == m_total) exp_done = 1'b1;
    end else if (!m_busy && start) begin
      if (total_cnt == '0) exp_done = 1'b1;
      else begin
        m_busy  = 1'b1;
        m_total = int'(total_cnt);
        m_sent  = 0;
      end
    end

    check("done", 32'(done), 32'(exp_done));
    check("busy", 32'(busy), 32'(m_busy));
    check("sent_cnt", 32'(sent_cnt), 32'(m_sent));
    if (done) n_done++;

    if (prev_valid && !xfer && !abort) begin
      check("hold_valid", 32'(drv_valid), 1);
      check("hold_data", 32'(drv_data), 32'(held_d));
      check("hold_src", 32'(drv_src), 32'(held_s));
    end else if (prev_valid) begin
      check("drop_valid", 32'(drv_valid), 0);
    end else begin
      check("grant_timing", 32'(drv_valid), 32'(grant_due));
    end
    new_item = !prev_valid && drv_valid;

    if (new_item && grant_due) begin
      winner = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (winner < 0 && item_v[idx]) winner = idx;
      end
      check("grant_src", 32'(drv_src), 32'(winner));
      check("req_next", 32'(req_next), 32'(1) << winner);
      exp_q.push_back(item_d[winner]);
      src_log.push_back(winner);
      m_ptr = (winner + 1) % NREQ;
    end else begin
      check("req_next_quiet", 32'(req_next), 0);
    end
    if (req_next[0]) n_next0++;
    n_next += $countones(req_next);
    item_v = item_v & ~req_next;

    arb_prev   = m_busy && !exp_done && !drv_valid;
    done_prev  = exp_done;
    prev_valid = drv_valid;
    held_d     = drv_data;
    held_s     = drv_src;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (item_v[i] && $urandom_range(0, 99) < withdraw_pct) item_v[i] = 1'b0;
      else if (!item_v[i] && gen_mask[i] && $urandom_range(0, 99) < refill_pct) begin
        item_v[i] = 1'b1;
        item_d[i] = DW'($urandom);
      end
    end
    drv_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    start = 1'b0;
    abort = 1'b0;
    drive_inputs();
  endtask

  task automatic fill_all(input logic [NREQ-1:0] mask);
    gen_mask = mask;
    for (int i = 0; i < NREQ; i++) item_d[i] = DW'($urandom);
    item_v = mask;
  endtask

  // Asynchronous reset raised between clock edges; outputs must clear at once.
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_drv_valid", 32'(drv_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sent_cnt", 32'(sent_cnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_req_next", 32'(req_next), 0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    m_busy = 0; m_sent = 0; m_ptr = 0; m_total = 0;
    prev_valid = 0; arb_prev = 0; done_prev = 0;
    exp_q.delete();
  endtask

  task automatic run_to_idle(input int budget);
    int c;
    c = 0;
    do begin
      tick();
      c++;
    end while (m_busy && c < budget);
    check("run_timeout", 32'(m_busy), 0);
  endtask

  // ---------------- scenarios ----------------
  int c, done_at, n0, nd, nn, abort_at, s_sent;
  logic [DW-1:0] s_data;
  logic [SW-1:0] s_src;

  initial begin
    for (int i = 0; i < NREQ; i++) item_d[i] = '0;
    apply_reset();

    // Reset while an item is waiting in SEND.
    fill_all('1);
    refill_pct = 100; ready_pct = 100; drv_ready = 1'b1;
    total_cnt = 16'd5; start = 1'b1;
    c = 0;
    do begin tick(); c++; end while (!(m_sent == 2 && drv_valid) && c < 40);
    check("t1_reach_send", 32'(drv_valid), 1);
    drv_ready = 1'b0; ready_pct = 0;
    apply_reset();

    // Single source, ten items.
    fill_all(4'b0001);
    ready_pct = 100; drv_ready = 1'b1;
    src_log.delete();
    n0 = n_next0; nd = n_done; done_at = 0;
    total_cnt = 16'd10; start = 1'b1;
    c = 0;
    do begin
      tick(); c++;
      if (done && done_at == 0) done_at = c;
    end while (m_busy && c < 80);
    check("t2_timeout", 32'(m_busy), 0);
    check("t2_done_cycle", 32'(done_at), 21);
    check("t2_req_next0", 32'(n_next0 - n0), 10);
    check("t2_done_count", 32'(n_done - nd), 1);
    check("t2_items", 32'(src_log.size()), 10);
    foreach (src_log[k]) check("t2_src", 32'(src_log[k]), 0);

    // Fairness from a fresh pointer.
    apply_reset();
    fill_all('1);
    src_log.delete();
    total_cnt = 16'd8; start = 1'b1;
    run_to_idle(80);
    check("t3_items", 32'(src_log.size()), 8);
    foreach (src_log[k]) check("t3_src_seq", 32'(src_log[k]), 32'(k % NREQ));

    // Backpressure for five cycles.
    fill_all('1);
    total_cnt = 16'd3; start = 1'b1;
    c = 0;
    do begin tick(); c++; end while (!drv_valid && c < 10);
    check("t4_reach_send", 32'(drv_valid), 1);
    drv_ready = 1'b0; ready_pct = 0;
    s_sent = int'(sent_cnt); s_data = drv_data; s_src = drv_src; nn = n_next;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_data_stable", 32'(drv_data), 32'(s_data));
      check("t4_src_stable", 32'(drv_src), 32'(s_src));
    end
    check("t4_no_extra_next", 32'(n_next - nn), 0);
    ready_pct = 100; drv_ready = 1'b1;
    tick();
    check("t4_sent_once", 32'(sent_cnt), 32'(s_sent + 1));
    run_to_idle(40);

    // Zero-length run.
    total_cnt = 16'd0; start = 1'b1;
    tick();
    check("t5_done", 32'(done), 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_no_valid", 32'(drv_valid), 0);
    end

    // Abort after three transfers, then resume at the kept pointer.
    apply_reset();
    fill_all(4'b0111);
    nd = n_done;
    total_cnt = 16'd10; start = 1'b1;
    c = 0;
    do begin tick(); c++; end while (!(m_sent == 3 && drv_valid) && c < 40);
    check("t6_reach_send", 32'(drv_valid), 1);
    abort = 1'b1;
    tick();
    check("t6_busy", 32'(busy), 0);
    check("t6_drv_valid", 32'(drv_valid), 0);
    check("t6_sent", 32'(sent_cnt), 3);
    check("t6_state", 32'(state_dbg), 32'(IDLE));
    for (int k = 0; k < 3; k++) tick();
    check("t6_no_done", 32'(n_done - nd), 0);
    fill_all('1);
    src_log.delete();
    total_cnt = 16'd2; start = 1'b1;
    run_to_idle(40);
    check("t6_items", 32'(src_log.size()), 2);
    if (src_log.size() == 2) begin
      check("t6_resume_src0", 32'(src_log[0]), 1);
      check("t6_resume_src1", 32'(src_log[1]), 2);
    end

    // Randomized runs with backpressure, withdrawals, stray starts and aborts.
    for (int r = 0; r < 30; r++) begin
      gen_mask     = '1;
      refill_pct   = $urandom_range(30, 100);
      withdraw_pct = 5;
      ready_pct    = $urandom_range(30, 100);
      total_cnt    = CW'($urandom_range(0, 12));
      start        = 1'b1;
      abort_at     = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 20) : -1;
      c = 0;
      do begin
        tick();
        c++;
        if (c == abort_at && m_busy) abort = 1'b1;
        else if (m_busy && $urandom_range(0, 9) == 0) begin
          start = 1'b1;
          total_cnt = CW'($urandom_range(0, 12));
        end
      end while (m_busy && c < 400);
      check("rand_timeout", 32'(m_busy), 0);
    end
    withdraw_pct = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
